wb_stage_pipe: RTL and testbench

Registered, parametrised writeback stage for the RISC-V pipeline. It accepts one retiring instruction per cycle from MEM, aligns and sign-extends load data, and produces the link value for jumps. It drives the GPR write port, mirrors that write as a forwarding bus, and keeps a retired-instruction counter. It supersedes the purely combinational writeback by adding a MEM/WB capture register, stall/flush handling, sub-word loads, x0 suppression and error reporting.

---
 rtl/wb_pkg.sv | 26 ++
 rtl/wb_load_align.sv | 43 ++++
 rtl/wb_stage_pipe.sv | 117 +++++++++++
 tb/tb_wb_stage_pipe.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants for the writeback stage: instruction class codes,
// load funct3 encodings and the hard-wired zero register address.
package wb_pkg;

  typedef enum logic [2:0] {
    T_LOAD  = 3'b000,
    T_LOGIC = 3'b001,
    T_S     = 3'b010,
    T_R     = 3'b011,
    T_RSVD  = 3'b100,
    T_U     = 3'b101,
    T_JUMP  = 3'b110,
    T_B     = 3'b111
  } wb_type_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [4:0] X0_ADDR = 5'd0;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load alignment: picks the addressed byte/half/word out of
// the naturally aligned memory word and sign- or zero-extends it.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = (XLEN == 64) ? 3 : 2
) (
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] offset,
  input  logic [XLEN-1:0]  lmd,
  output logic [XLEN-1:0]  data,
  output logic             err
);

  logic [XLEN-1:0] shifted;

  // Move the addressed lane down to bit 0 so every size reads from the bottom.
  assign shifted = lmd >> {offset, 3'b000};

  always_comb begin
    data = '0;
    err  = 1'b0;
    case (funct3)
      F3_LB:  data = XLEN'($signed(shifted[7:0]));
      F3_LBU: data = XLEN'(shifted[7:0]);
      F3_LH:  if (offset[0]) err = 1'b1; else data = XLEN'($signed(shifted[15:0]));
      F3_LHU: if (offset[0]) err = 1'b1; else data = XLEN'(shifted[15:0]);
      F3_LW:  if (offset[1:0] != 2'b00) err = 1'b1; else data = XLEN'($signed(shifted[31:0]));
      F3_LWU: begin
        if (XLEN != 64 || offset[1:0] != 2'b00) err = 1'b1;
        else data = XLEN'(shifted[31:0]);
      end
      F3_LD: begin
        if (XLEN != 64 || offset != '0) err = 1'b1;
        else data = lmd;
      end
      default: err = 1'b1;
    endcase
    if (err) data = '0;
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// Registered writeback stage: captures one retiring instruction per cycle,
// produces the GPR write / forwarding copy, load errors and the retire count.
module wb_stage_pipe
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RET_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  input  logic             flush,
  input  logic [2:0]       in_type,
  input  logic [31:0]      in_ir,
  input  logic [XLEN-1:0]  in_aluout,
  input  logic [XLEN-1:0]  in_lmd,
  input  logic [XLEN-1:0]  in_pc,
  output logic             en_GPR,
  output logic [4:0]       data_addr,
  output logic [XLEN-1:0]  data_in,
  output logic             fwd_valid,
  output logic [4:0]       fwd_addr,
  output logic [XLEN-1:0]  fwd_data,
  output logic             err,
  output logic             retire_pulse,
  output logic [RET_W-1:0] retire_count
);

  localparam int OFF_W = (XLEN == 64) ? 3 : 2;

  logic            accept;
  logic [4:0]      rd;
  logic [XLEN-1:0] load_data;
  logic            load_err;

  logic            wr_next;
  logic [4:0]      addr_next;
  logic [XLEN-1:0] data_next;
  logic            err_next;
  logic            ret_next;

  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready & ~flush;
  assign rd       = in_ir[11:7];

  wb_load_align #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_align (
    .funct3 (in_ir[14:12]),
    .offset (in_aluout[OFF_W-1:0]),
    .lmd    (in_lmd),
    .data   (load_data),
    .err    (load_err)
  );

  always_comb begin
    wr_next   = 1'b0;
    data_next = '0;
    err_next  = 1'b0;
    ret_next  = 1'b0;
    addr_next = X0_ADDR;
    if (accept) begin
      case (wb_type_e'(in_type))
        T_R, T_U, T_LOGIC: begin
          wr_next   = 1'b1;
          data_next = in_aluout;
          ret_next  = 1'b1;
        end
        T_JUMP: begin
          wr_next   = 1'b1;
          data_next = in_pc + XLEN'(4);
          ret_next  = 1'b1;
        end
        T_LOAD: begin
          if (load_err) begin
            err_next = 1'b1;
          end else begin
            wr_next   = 1'b1;
            data_next = load_data;
            ret_next  = 1'b1;
          end
        end
        default: ret_next = 1'b1;
      endcase
    end
    // x0 writes are dropped but the instruction still retires.
    if (rd == X0_ADDR) wr_next = 1'b0;
    if (wr_next) addr_next = rd;
    else data_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_GPR       <= 1'b0;
      data_addr    <= '0;
      data_in      <= '0;
      err          <= 1'b0;
      retire_pulse <= 1'b0;
      retire_count <= '0;
    end else begin
      en_GPR       <= wr_next;
      data_addr    <= addr_next;
      data_in      <= data_next;
      err          <= err_next;
      retire_pulse <= ret_next;
      if (ret_next) retire_count <= retire_count + 1'b1;
    end
  end

  assign fwd_valid = en_GPR;
  assign fwd_addr  = data_addr;
  assign fwd_data  = data_in;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Self-checking bench for wb_stage_pipe (XLEN=32, RET_W=4): directed literal
// cases followed by randomized traffic checked against a behavioural model.
module tb_wb_stage_pipe;

  localparam int XLEN  = 32;
  localparam int RET_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             stall;
  logic             flush;
  logic [2:0]       in_type;
  logic [31:0]      in_ir;
  logic [XLEN-1:0]  in_aluout;
  logic [XLEN-1:0]  in_lmd;
  logic [XLEN-1:0]  in_pc;
  logic             en_GPR;
  logic [4:0]       data_addr;
  logic [XLEN-1:0]  data_in;
  logic             fwd_valid;
  logic [4:0]       fwd_addr;
  logic [XLEN-1:0]  fwd_data;
  logic             err;
  logic             retire_pulse;
  logic [RET_W-1:0] retire_count;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  wb_stage_pipe #(.XLEN(XLEN), .RET_W(RET_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .stall        (stall),
    .flush        (flush),
    .in_type      (in_type),
    .in_ir        (in_ir),
    .in_aluout    (in_aluout),
    .in_lmd       (in_lmd),
    .in_pc        (in_pc),
    .en_GPR       (en_GPR),
    .data_addr    (data_addr),
    .data_in      (data_in),
    .fwd_valid    (fwd_valid),
    .fwd_addr     (fwd_addr),
    .fwd_data     (fwd_data),
    .err          (err),
    .retire_pulse (retire_pulse),
    .retire_count (retire_count)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    logic        e;
    logic        r;
  } res_t;

  // Reference: what a single accepted instruction must produce.
  function automatic res_t ref_model(input logic [2:0] t, input logic [31:0] ir,
                                     input logic [31:0] alu, input logic [31:0] lmd,
                                     input logic [31:0] pc);
    res_t        res;
    int unsigned f3;
    int unsigned off;
    logic [31:0] lane;
    res  = '0;
    f3   = ir[14:12];
    off  = alu[1:0];
    lane = lmd >> (8 * off);
    case (t)
      3'd1, 3'd3, 3'd5: begin res.we = 1; res.d = alu; res.r = 1; end
      3'd6:             begin res.we = 1; res.d = pc + 32'd4; res.r = 1; end
      3'd0: begin
        case (f3)
          0: res.d = lane[7] ? (32'hFFFF_FF00 | (lane & 32'hFF)) : (lane & 32'hFF);
          4: res.d = lane & 32'hFF;
          1: if (off % 2 != 0) res.e = 1;
             else res.d = lane[15] ? (32'hFFFF_0000 | (lane & 32'hFFFF)) : (lane & 32'hFFFF);
          5: if (off % 2 != 0) res.e = 1; else res.d = lane & 32'hFFFF;
          2: if (off != 0) res.e = 1; else res.d = lmd;
          default: res.e = 1;
        endcase
        if (!res.e) begin res.we = 1; res.r = 1; end
        else res.d = 0;
      end
      default: res.r = 1;
    endcase
    if (ir[11:7] == 5'd0) res.we = 0;
    if (res.we) res.a = ir[11:7];
    else res.d = 0;
    return res;
  endfunction

  res_t             exp_res;
  logic [RET_W-1:0] exp_count;
  logic             acc_now;
  res_t             cur_res;

  assign acc_now = in_valid && !stall && !flush;
  assign cur_res = ref_model(in_type, in_ir, in_aluout, in_lmd, in_pc);

  always @(posedge clk) begin
    if (rst) begin
      exp_res   <= '0;
      exp_count <= '0;
    end else begin
      exp_res   <= acc_now ? cur_res : '0;
      exp_count <= exp_count + ((acc_now && cur_res.r) ? 1 : 0);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready",     64'(in_ready),     64'(!stall));
      chk("en_GPR",       64'(en_GPR),       64'(exp_res.we));
      chk("data_addr",    64'(data_addr),    64'(exp_res.a));
      chk("data_in",      64'(data_in),      64'(exp_res.d));
      chk("fwd_valid",    64'(fwd_valid),    64'(exp_res.we));
      chk("fwd_addr",     64'(fwd_addr),     64'(exp_res.a));
      chk("fwd_data",     64'(fwd_data),     64'(exp_res.d));
      chk("err",          64'(err),          64'(exp_res.e));
      chk("retire_pulse", 64'(retire_pulse), 64'(exp_res.r));
      chk("retire_count", 64'(retire_count), 64'(exp_count));
    end
  end

  function automatic logic [31:0] mk_ir(input logic [2:0] f3, input logic [4:0] rd);
    return {17'h0, f3, rd, 7'h03};
  endfunction

  task automatic step(input logic r, input logic v, input logic s, input logic f,
                      input logic [2:0] t, input logic [31:0] ir, input logic [31:0] alu,
                      input logic [31:0] lmd, input logic [31:0] pc);
    rst = r; in_valid = v; stall = s; flush = f;
    in_type = t; in_ir = ir; in_aluout = alu; in_lmd = lmd; in_pc = pc;
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("txn rst=%0b v=%0b s=%0b f=%0b type=%0d ir=%h -> en=%0b addr=%0d data=%h err=%0b ret=%0b cnt=%0d",
             r, v, s, f, t, ir, en_GPR, data_addr, data_in, err, retire_pulse, retire_count);
  endtask

  initial begin
    step(1, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    step(1, 1, 0, 0, 3'd3, mk_ir(3'd0, 5'd4), 32'h1, 32'h0, 32'h0);
    cmp_en = 1'b1;
    chk("lit_reset_en", 64'(en_GPR), 64'd0);
    chk("lit_reset_cnt", 64'(retire_count), 64'd0);

    step(0, 1, 0, 0, 3'd3, mk_ir(3'd0, 5'd5), 32'h1234_5678, 32'h0, 32'h0);
    chk("lit_r_en", 64'(en_GPR), 64'd1);
    chk("lit_r_addr", 64'(data_addr), 64'd5);
    chk("lit_r_data", 64'(data_in), 64'h1234_5678);
    chk("lit_r_fwd", 64'(fwd_data), 64'h1234_5678);
    chk("lit_r_cnt", 64'(retire_count), 64'd1);

    step(0, 1, 0, 0, 3'd0, mk_ir(3'b000, 5'd3), 32'h0000_1003, 32'h80FF_FF00, 32'h0);
    chk("lit_lb", 64'(data_in), 64'hFFFF_FF80);
    step(0, 1, 0, 0, 3'd0, mk_ir(3'b100, 5'd3), 32'h0000_1003, 32'h80FF_FF00, 32'h0);
    chk("lit_lbu", 64'(data_in), 64'h0000_0080);
    chk("lit_lbu_cnt", 64'(retire_count), 64'd3);

    step(0, 1, 0, 0, 3'd0, mk_ir(3'b001, 5'd3), 32'h0000_1001, 32'h80FF_FF00, 32'h0);
    chk("lit_lh_mis_err", 64'(err), 64'd1);
    chk("lit_lh_mis_en", 64'(en_GPR), 64'd0);
    chk("lit_lh_mis_cnt", 64'(retire_count), 64'd3);
    step(0, 1, 0, 0, 3'd0, mk_ir(3'b011, 5'd3), 32'h0000_1000, 32'h80FF_FF00, 32'h0);
    chk("lit_ld32_err", 64'(err), 64'd1);
    chk("lit_ld32_ret", 64'(retire_pulse), 64'd0);

    step(0, 1, 0, 0, 3'd6, mk_ir(3'b000, 5'd1), 32'h0, 32'h0, 32'hFFFF_FFFC);
    chk("lit_jal_en", 64'(en_GPR), 64'd1);
    chk("lit_jal_data", 64'(data_in), 64'h0);
    step(0, 1, 0, 0, 3'd1, mk_ir(3'b000, 5'd0), 32'hDEAD_BEEF, 32'h0, 32'h0);
    chk("lit_x0_en", 64'(en_GPR), 64'd0);
    chk("lit_x0_ret", 64'(retire_pulse), 64'd1);
    chk("lit_x0_cnt", 64'(retire_count), 64'd5);

    step(0, 1, 0, 0, 3'd3, mk_ir(3'b000, 5'd7), 32'h0000_0077, 32'h0, 32'h0);
    chk("lit_b2b1_en", 64'(en_GPR), 64'd1);
    step(0, 1, 0, 1, 3'd3, mk_ir(3'b000, 5'd8), 32'h0000_0088, 32'h0, 32'h0);
    chk("lit_flush_en", 64'(en_GPR), 64'd0);
    step(0, 1, 1, 0, 3'd3, mk_ir(3'b000, 5'd9), 32'h0000_0099, 32'h0, 32'h0);
    chk("lit_stall_en", 64'(en_GPR), 64'd0);
    chk("lit_stall_ready", 64'(in_ready), 64'd0);
    chk("lit_b2b_cnt", 64'(retire_count), 64'd6);

    step(0, 1, 0, 0, 3'd3, mk_ir(3'b000, 5'd9), 32'h0000_0099, 32'h0, 32'h0);
    step(1, 1, 0, 0, 3'd3, mk_ir(3'b000, 5'd10), 32'h0000_00AA, 32'h0, 32'h0);
    chk("lit_rst_en", 64'(en_GPR), 64'd0);
    chk("lit_rst_data", 64'(data_in), 64'd0);
    chk("lit_rst_cnt", 64'(retire_count), 64'd0);

    for (int i = 0; i < 15; i++)
      step(0, 1, 0, 0, 3'd2, mk_ir(3'b010, 5'd0), 32'h0, 32'h0, 32'h0);
    chk("lit_cnt15", 64'(retire_count), 64'd15);
    step(0, 1, 0, 0, 3'd7, mk_ir(3'b000, 5'd0), 32'h0, 32'h0, 32'h0);
    chk("lit_wrap", 64'(retire_count), 64'd0);
    chk("lit_wrap_ret", 64'(retire_pulse), 64'd1);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] ir;
      ir = $urandom;
      if ($urandom_range(0, 7) == 0) ir[11:7] = 5'd0;
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           3'($urandom_range(0, 7)), ir, $urandom, $urandom, $urandom);
    end

    step(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
